// File: rtl/regfile_scoreboard_if.sv
// Issue/read/writeback bundle between decode-issue, writeback and the register file.
// master = pipeline side driving pointers and writes, slave = register file.
interface regfile_scoreboard_if #(
  parameter int N    = 32,
  parameter int Bits = 64,
  parameter int NRD  = 2
) ();
  localparam int AW = $clog2(N);

  logic [NRD*AW-1:0]   ptr_rd;
  logic [NRD*Bits-1:0] data_rd;
  logic                wr_en;
  logic [AW-1:0]       ptr_wr;
  logic [Bits-1:0]     data_wr;
  logic                iss_en;
  logic [NRD-1:0]      iss_uses;
  logic [AW-1:0]       iss_rd;
  logic                stall;
  logic [N-1:0]        busy_vec;
  logic                wb_err;

  modport master (
    output ptr_rd, wr_en, ptr_wr, data_wr, iss_en, iss_uses, iss_rd,
    input  data_rd, stall, busy_vec, wb_err
  );

  modport slave (
    input  ptr_rd, wr_en, ptr_wr, data_wr, iss_en, iss_uses, iss_rd,
    output data_rd, stall, busy_vec, wb_err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised integer register file with optional write-to-read bypass and an
// integrated busy-bit scoreboard that stalls issue on RAW/WAW hazards.
module regfile_scoreboard #(
  parameter int N      = 32,
  parameter int Bits   = 64,
  parameter int NRD    = 2,
  parameter bit BYPASS = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  regfile_scoreboard_if.slave  rf
);
  localparam int AW = $clog2(N);

  logic [Bits-1:0] regs_q [N];
  logic [Bits-1:0] regs_d [N];
  logic [N-1:0]    busy_q;
  logic [N-1:0]    busy_d;
  logic            wb_err_q;
  logic            wb_err_d;

  logic                wr_fire;
  logic                src_haz;
  logic                dst_haz;
  logic                stall;
  logic                iss_accept;
  logic [AW-1:0]       ptr_k;
  logic                bypass_hit;
  logic [NRD*Bits-1:0] rd_data;

  assign wr_fire = rf.wr_en && (rf.ptr_wr != '0);

  // Per-port read mux and source-hazard check; x0 always reads zero and never stalls.
  always_comb begin
    rd_data    = '0;
    src_haz    = 1'b0;
    ptr_k      = '0;
    bypass_hit = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      ptr_k      = rf.ptr_rd[k*AW +: AW];
      bypass_hit = BYPASS && wr_fire && (rf.ptr_wr == ptr_k);
      if (ptr_k != '0) begin
        rd_data[k*Bits +: Bits] = bypass_hit ? rf.data_wr : regs_q[ptr_k];
        if (rf.iss_uses[k] && busy_q[ptr_k] && !bypass_hit)
          src_haz = 1'b1;
      end
    end
  end

  // A destination being retired this cycle is free for the new writer regardless of bypass.
  always_comb begin
    dst_haz = (rf.iss_rd != '0) && busy_q[rf.iss_rd] &&
              !(wr_fire && (rf.ptr_wr == rf.iss_rd));
  end

  assign stall      = rf.iss_en && (src_haz || dst_haz);
  assign iss_accept = rf.iss_en && !stall;

  // Set is applied after clear so a same-cycle reissue keeps the register busy.
  always_comb begin
    busy_d   = busy_q;
    wb_err_d = wb_err_q;
    for (int i = 0; i < N; i++) regs_d[i] = regs_q[i];
    if (wr_fire) begin
      regs_d[rf.ptr_wr] = rf.data_wr;
      busy_d[rf.ptr_wr] = 1'b0;
      if (!busy_q[rf.ptr_wr]) wb_err_d = 1'b1;
    end
    if (iss_accept && (rf.iss_rd != '0))
      busy_d[rf.iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) regs_q[i] <= '0;
      busy_q   <= '0;
      wb_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) regs_q[i] <= regs_d[i];
      busy_q   <= busy_d;
      wb_err_q <= wb_err_d;
    end
  end

  assign rf.data_rd  = rd_data;
  assign rf.stall    = stall;
  assign rf.busy_vec = busy_q;
  assign rf.wb_err   = wb_err_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one bypass and one non-bypass instance
// share the same stimulus so bypass-dependent behaviour is compared side by side.
module tb_regfile_scoreboard;
  localparam int N    = 32;
  localparam int Bits = 64;
  localparam int NRD  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NRD*5-1:0] ptr_rd;
  logic             wr_en;
  logic [4:0]       ptr_wr;
  logic [Bits-1:0]  data_wr;
  logic             iss_en;
  logic [NRD-1:0]   iss_uses;
  logic [4:0]       iss_rd;

  int errors = 0;
  int checks = 0;

  regfile_scoreboard_if #(.N(N), .Bits(Bits), .NRD(NRD)) ifb ();
  regfile_scoreboard_if #(.N(N), .Bits(Bits), .NRD(NRD)) ifn ();

  assign ifb.ptr_rd   = ptr_rd;
  assign ifb.wr_en    = wr_en;
  assign ifb.ptr_wr   = ptr_wr;
  assign ifb.data_wr  = data_wr;
  assign ifb.iss_en   = iss_en;
  assign ifb.iss_uses = iss_uses;
  assign ifb.iss_rd   = iss_rd;
  assign ifn.ptr_rd   = ptr_rd;
  assign ifn.wr_en    = wr_en;
  assign ifn.ptr_wr   = ptr_wr;
  assign ifn.data_wr  = data_wr;
  assign ifn.iss_en   = iss_en;
  assign ifn.iss_uses = iss_uses;
  assign ifn.iss_rd   = iss_rd;

  regfile_scoreboard #(.N(N), .Bits(Bits), .NRD(NRD), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst(rst), .rf(ifb)
  );
  regfile_scoreboard #(.N(N), .Bits(Bits), .NRD(NRD), .BYPASS(1'b0)) dut_n (
    .clk(clk), .rst(rst), .rf(ifn)
  );

  always #5 clk = ~clk;

  task automatic idle();
    ptr_rd   = '0;
    wr_en    = 1'b0;
    ptr_wr   = '0;
    data_wr  = '0;
    iss_en   = 1'b0;
    iss_uses = '0;
    iss_rd   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    idle();
    rst = 1'b1;
    @(negedge clk);
    // State must stay cleared across an edge while rst is held.
    wr_en = 1'b1; ptr_wr = 5'd3; data_wr = 64'hFF;
    iss_en = 1'b1; iss_rd = 5'd5;
    tick();
    idle();
    rst = 1'b0;
    ptr_rd = {5'd5, 5'd0};
    iss_en = 1'b1; iss_uses = 2'b11;
    #1;
    checks++;
    if (ifb.data_rd !== '0) begin
      errors++; $display("[TB] FAIL reset_data_b got=%h exp=0", ifb.data_rd);
    end
    checks++;
    if (ifn.data_rd !== '0) begin
      errors++; $display("[TB] FAIL reset_data_n got=%h exp=0", ifn.data_rd);
    end
    checks++;
    if (ifb.busy_vec !== '0) begin
      errors++; $display("[TB] FAIL reset_busy got=%h exp=0", ifb.busy_vec);
    end
    checks++;
    if (ifb.stall !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_stall got=%b exp=0", ifb.stall);
    end
    checks++;
    if (ifb.wb_err !== 1'b0 || ifn.wb_err !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_wb_err got=%b/%b exp=0/0", ifb.wb_err, ifn.wb_err);
    end
    ptr_rd = {5'd0, 5'd3};
    #1;
    checks++;
    if (ifb.data_rd !== '0) begin
      errors++; $display("[TB] FAIL reset_held_reg3 got=%h exp=0", ifb.data_rd);
    end
    idle();
  endtask

  task automatic test_write_read();
    $display("[TB] test_write_read");
    do_reset();
    iss_en = 1'b1; iss_rd = 5'd3;
    tick();
    idle();
    wr_en = 1'b1; ptr_wr = 5'd3; data_wr = 64'hDEAD_BEEF;
    tick();
    ptr_wr = 5'd0; data_wr = 64'h1234;
    tick();
    idle();
    ptr_rd = {5'd0, 5'd3};
    #1;
    checks++;
    if (ifb.data_rd !== {64'h0, 64'hDEAD_BEEF}) begin
      errors++; $display("[TB] FAIL wr_rd_b got=%h exp=%h", ifb.data_rd, {64'h0, 64'hDEAD_BEEF});
    end
    checks++;
    if (ifn.data_rd !== {64'h0, 64'hDEAD_BEEF}) begin
      errors++; $display("[TB] FAIL wr_rd_n got=%h exp=%h", ifn.data_rd, {64'h0, 64'hDEAD_BEEF});
    end
    checks++;
    if (ifb.busy_vec !== '0 || ifb.wb_err !== 1'b0) begin
      errors++; $display("[TB] FAIL wr_rd_state busy=%h err=%b exp=0/0", ifb.busy_vec, ifb.wb_err);
    end
    ptr_rd = {5'd3, 5'd3};
    #1;
    checks++;
    if (ifn.data_rd !== {64'hDEAD_BEEF, 64'hDEAD_BEEF}) begin
      errors++; $display("[TB] FAIL wr_rd_alias got=%h exp=both deadbeef", ifn.data_rd);
    end
    idle();
  endtask

  task automatic test_bypass();
    $display("[TB] test_bypass");
    do_reset();
    wr_en = 1'b1; ptr_wr = 5'd7; data_wr = 64'h11;
    tick();
    data_wr = 64'hA5;
    ptr_rd = {5'd0, 5'd7};
    #1;
    checks++;
    if (ifb.data_rd[63:0] !== 64'hA5) begin
      errors++; $display("[TB] FAIL bypass_on got=%h exp=a5", ifb.data_rd[63:0]);
    end
    checks++;
    if (ifn.data_rd[63:0] !== 64'h11) begin
      errors++; $display("[TB] FAIL bypass_off_old got=%h exp=11", ifn.data_rd[63:0]);
    end
    tick();
    wr_en = 1'b0;
    #1;
    checks++;
    if (ifn.data_rd[63:0] !== 64'hA5) begin
      errors++; $display("[TB] FAIL bypass_off_next got=%h exp=a5", ifn.data_rd[63:0]);
    end
    wr_en = 1'b1; ptr_wr = 5'd0; data_wr = 64'hFF;
    ptr_rd = {5'd7, 5'd0};
    #1;
    checks++;
    if (ifb.data_rd !== {64'hA5, 64'h0}) begin
      errors++; $display("[TB] FAIL bypass_x0 got=%h exp=%h", ifb.data_rd, {64'hA5, 64'h0});
    end
    idle();
  endtask

  task automatic test_raw_stall();
    $display("[TB] test_raw_stall");
    do_reset();
    iss_en = 1'b1; iss_rd = 5'd4;
    #1;
    checks++;
    if (ifb.stall !== 1'b0) begin
      errors++; $display("[TB] FAIL raw_first_issue got=%b exp=0", ifb.stall);
    end
    tick();
    iss_rd = 5'd0;
    ptr_rd = {5'd4, 5'd0};
    iss_uses = 2'b10;
    #1;
    checks++;
    if (ifb.busy_vec !== 32'h10) begin
      errors++; $display("[TB] FAIL raw_busy got=%h exp=10", ifb.busy_vec);
    end
    checks++;
    if (ifb.stall !== 1'b1 || ifn.stall !== 1'b1) begin
      errors++; $display("[TB] FAIL raw_stall got=%b/%b exp=1/1", ifb.stall, ifn.stall);
    end
    iss_uses = 2'b01;
    #1;
    checks++;
    if (ifb.stall !== 1'b0 || ifn.stall !== 1'b0) begin
      errors++; $display("[TB] FAIL raw_unused_port got=%b/%b exp=0/0", ifb.stall, ifn.stall);
    end
    iss_uses = 2'b10;
    wr_en = 1'b1; ptr_wr = 5'd4; data_wr = 64'h44;
    #1;
    checks++;
    if (ifb.stall !== 1'b0 || ifn.stall !== 1'b1) begin
      errors++; $display("[TB] FAIL raw_wb_same_cycle got=%b/%b exp=0/1", ifb.stall, ifn.stall);
    end
    tick();
    wr_en = 1'b0;
    #1;
    checks++;
    if (ifb.stall !== 1'b0 || ifn.stall !== 1'b0) begin
      errors++; $display("[TB] FAIL raw_after_wb got=%b/%b exp=0/0", ifb.stall, ifn.stall);
    end
    checks++;
    if (ifn.data_rd[127:64] !== 64'h44) begin
      errors++; $display("[TB] FAIL raw_data got=%h exp=44", ifn.data_rd[127:64]);
    end
    idle();
  endtask

  task automatic test_waw_set_wins();
    $display("[TB] test_waw_set_wins");
    do_reset();
    iss_en = 1'b1; iss_rd = 5'd9;
    tick();
    #1;
    checks++;
    if (ifb.stall !== 1'b1 || ifn.stall !== 1'b1) begin
      errors++; $display("[TB] FAIL waw_stall got=%b/%b exp=1/1", ifb.stall, ifn.stall);
    end
    tick();
    wr_en = 1'b1; ptr_wr = 5'd9; data_wr = 64'h99;
    #1;
    checks++;
    if (ifb.stall !== 1'b0 || ifn.stall !== 1'b0) begin
      errors++; $display("[TB] FAIL waw_retire_reissue got=%b/%b exp=0/0", ifb.stall, ifn.stall);
    end
    tick();
    idle();
    iss_rd = 5'd9;
    #1;
    checks++;
    if (ifb.busy_vec !== 32'h200 || ifn.busy_vec !== 32'h200) begin
      errors++; $display("[TB] FAIL waw_set_wins got=%h/%h exp=200", ifb.busy_vec, ifn.busy_vec);
    end
    checks++;
    if (ifb.stall !== 1'b0 || ifb.wb_err !== 1'b0) begin
      errors++; $display("[TB] FAIL waw_idle_stall_err got=%b/%b exp=0/0", ifb.stall, ifb.wb_err);
    end
    idle();
  endtask

  task automatic test_error_async_reset();
    $display("[TB] test_error_async_reset");
    do_reset();
    wr_en = 1'b1; ptr_wr = 5'd2; data_wr = 64'h5;
    #1;
    checks++;
    if (ifb.wb_err !== 1'b0) begin
      errors++; $display("[TB] FAIL err_before_edge got=%b exp=0", ifb.wb_err);
    end
    tick();
    idle();
    iss_en = 1'b1; iss_rd = 5'd6;
    ptr_rd = {5'd0, 5'd2};
    #1;
    checks++;
    if (ifb.wb_err !== 1'b1 || ifn.wb_err !== 1'b1) begin
      errors++; $display("[TB] FAIL err_set got=%b/%b exp=1/1", ifb.wb_err, ifn.wb_err);
    end
    checks++;
    if (ifb.data_rd[63:0] !== 64'h5) begin
      errors++; $display("[TB] FAIL err_write_done got=%h exp=5", ifb.data_rd[63:0]);
    end
    tick();
    iss_en = 1'b0; iss_rd = 5'd0;
    #1;
    checks++;
    if (ifb.wb_err !== 1'b1 || ifb.busy_vec !== 32'h40) begin
      errors++; $display("[TB] FAIL err_sticky got=%b busy=%h exp=1 busy=40", ifb.wb_err, ifb.busy_vec);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (ifb.wb_err !== 1'b0 || ifb.busy_vec !== '0 || ifb.data_rd !== '0) begin
      errors++; $display("[TB] FAIL async_reset got err=%b busy=%h data=%h exp=0", ifb.wb_err, ifb.busy_vec, ifb.data_rd);
    end
    #1;
    rst = 1'b0;
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_raw_stall();
    test_waw_set_wins();
    test_error_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
